// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one W-bit adder among NREQ valid/ready requesters,
// with multi-beat carry chaining and a one-deep response slot. Optional: ADDER_SCHED_STATS_EN.
module adder_rr_scheduler #(
    parameter int unsigned INPUT_LEN = 16,
    parameter int unsigned W         = INPUT_LEN,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_o,
    input  logic              add_cout,
`ifdef ADDER_SCHED_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_beats,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_last_q, rsp_last_d;

    logic           slot_free;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic           accept;
    logic           chain_g;

    assign slot_free = !rsp_valid_q || rsp_ready;

    // grant_valid already implies req_valid of the winner, so a locked but idle
    // requester produces no grant and no req_ready.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        if (state_q == ST_LOCKED) begin
            grant_id    = lock_id_q;
            grant_valid = req_valid[lock_id_q];
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = IDW'((32'(ptr_q) + k) % NREQ);
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    assign accept  = grant_valid && slot_free;
    assign chain_g = req_chain[grant_id];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant_valid) begin
            add_a   = req_a[32'(grant_id)*W +: W];
            add_b   = req_b[32'(grant_id)*W +: W];
            add_cin = (state_q == ST_LOCKED) ? carry_q : req_cin[grant_id];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_o;
            rsp_cout_d  = add_cout;
            rsp_id_d    = grant_id;
            rsp_last_d  = !chain_g;
            if (chain_g) begin
                state_d   = ST_LOCKED;
                lock_id_d = grant_id;
                carry_d   = add_cout;
            end else begin
                state_d = ST_UNLOCKED;
                ptr_d   = IDW'((32'(grant_id) + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            ptr_q       <= '0;
            lock_id_q   <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_id_q   <= lock_id_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

`ifdef ADDER_SCHED_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Clear has priority over a same-cycle accept; the count saturates at all-ones.
    always_comb begin
        stat_d = stat_q;
        if (stat_clr) begin
            stat_d = '0;
        end else if (accept && (stat_q != '1)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler; the shared adder is modelled here as a plain
// (W+1)-bit sum. Stats checks compile only with ADDER_SCHED_STATS_EN defined.
module tb_adder_rr_scheduler;

    localparam int unsigned W    = 16;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_o;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_last;
`ifdef ADDER_SCHED_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_beats;
`endif

    int checks = 0;
    int errors = 0;

    adder_rr_scheduler #(
        .INPUT_LEN(W),
        .W(W),
        .NREQ(NREQ),
        .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_cin(req_cin),
        .req_chain(req_chain),
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_o(add_o),
        .add_cout(add_cout),
`ifdef ADDER_SCHED_STATS_EN
        .stat_clr(stat_clr),
        .stat_beats(stat_beats),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout),
        .rsp_last(rsp_last)
    );

    // Shared adder model
    logic [W:0] add_full;
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_o    = add_full[W-1:0];
    assign add_cout = add_full[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic chain);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_chain[i]    = chain;
    endtask

    task automatic check_rsp(input string tag, input logic [IDW-1:0] id, input logic [W-1:0] sum,
                             input logic cout, input logic last);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".sum"},   32'(rsp_sum),   32'(sum));
        check({tag, ".cout"},  32'(rsp_cout),  32'(cout));
        check({tag, ".last"},  32'(rsp_last),  32'(last));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b0;
`ifdef ADDER_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        tick();
        tick();
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_sum",   32'(rsp_sum),   32'd0);
        check("rst.rsp_cout",  32'(rsp_cout),  32'd0);
        check("rst.rsp_id",    32'(rsp_id),    32'd0);
        check("rst.rsp_last",  32'(rsp_last),  32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Single beat from req0
        rsp_ready = 1'b1;
        set_req(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("single.req_ready", 32'(req_ready), 32'h1);
        check("single.add_a",     32'(add_a),     32'h00FF);
        tick();
        req_valid = '0;
        check_rsp("single", 2'd0, 16'h0100, 1'b0, 1'b1);

        // req3 alone, with carry-in; moves ptr back to 0
        set_req(3, 16'h0001, 16'h0002, 1'b1, 1'b0);
        req_valid = 4'b1000;
        #1;
        check("cin.req_ready", 32'(req_ready), 32'h8);
        check("cin.add_cin",   32'(add_cin),   32'd1);
        tick();
        req_valid = '0;
        check_rsp("cin", 2'd3, 16'h0004, 1'b0, 1'b1);

        // Round-robin: all valid, expect 0,1,2,3,0
        for (int unsigned i = 0; i < NREQ; i++) begin
            set_req(i, W'(32'h1000 * i + 1), W'(i), 1'b0, 1'b0);
        end
        req_valid = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            int unsigned g;
            g = k % NREQ;
            #1;
            check("rr.req_ready", 32'(req_ready), 32'(1) << g);
            tick();
            check("rr.rsp_id",  32'(rsp_id),  g);
            check("rr.rsp_sum", 32'(rsp_sum), 32'h1000 * g + 1 + g);
        end
        req_valid = '0;

        // req1 alone so ptr points at req2
        set_req(1, 16'h0005, 16'h0003, 1'b0, 1'b0);
        req_valid = 4'b0010;
        tick();
        check_rsp("pre", 2'd1, 16'h0008, 1'b0, 1'b1);

        // Chain on req2 with req1 competing, including a lock-hold gap
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        req_valid = 4'b0110;
        #1;
        check("chain0.req_ready", 32'(req_ready), 32'h4);
        tick();
        check_rsp("chain0", 2'd2, 16'h0000, 1'b1, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("hold.req_ready", 32'(req_ready), 32'h0);
        tick();
        check("hold.rsp_valid", 32'(rsp_valid), 32'd0);
        check("hold.rsp_last",  32'(rsp_last),  32'd0);
        set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        req_valid = 4'b0110;
        #1;
        check("chain1.req_ready", 32'(req_ready), 32'h4);
        check("chain1.add_cin",   32'(add_cin),   32'd1);
        tick();
        check_rsp("chain1", 2'd2, 16'h0001, 1'b0, 1'b1);
        req_valid = 4'b0010;
        #1;
        check("after.req_ready", 32'(req_ready), 32'h2);
        tick();
        check_rsp("after", 2'd1, 16'h0008, 1'b0, 1'b1);
        req_valid = '0;
        tick();

        // Backpressure
        rsp_ready = 1'b0;
        set_req(3, 16'h1234, 16'h1111, 1'b0, 1'b0);
        req_valid = 4'b1000;
        tick();
        check_rsp("bp.load", 2'd3, 16'h2345, 1'b0, 1'b1);
        set_req(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("bp.req_ready", 32'(req_ready), 32'h0);
        tick();
        check_rsp("bp.hold", 2'd3, 16'h2345, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        #1;
        check("bp.release.req_ready", 32'(req_ready), 32'h1);
        tick();
        check_rsp("bp.reload", 2'd0, 16'h0002, 1'b0, 1'b1);
        req_valid = '0;

        // Reset while locked to req1
        set_req(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        req_valid = 4'b0010;
        tick();
        check_rsp("lock1", 2'd1, 16'hFFFE, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        set_req(0, 16'h0010, 16'h0001, 1'b1, 1'b0);
        set_req(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        req_valid = 4'b0011;
        #1;
        check("rstmid.req_ready", 32'(req_ready), 32'h1);
        check("rstmid.add_cin",   32'(add_cin),   32'd1);
`ifdef ADDER_SCHED_STATS_EN
        check("stat.rst", 32'(stat_beats), 32'd0);
`endif
        tick();
        check_rsp("rstmid", 2'd0, 16'h0012, 1'b0, 1'b1);

`ifdef ADDER_SCHED_STATS_EN
        req_valid = 4'b0001;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
        end
        req_valid = '0;
        check("stat.five", 32'(stat_beats), 32'd5);
        req_valid = 4'b0001;
        stat_clr  = 1'b1;
        tick();
        stat_clr  = 1'b0;
        req_valid = '0;
        check("stat.clr", 32'(stat_beats), 32'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_scheduler.md
# adder_rr_scheduler

Round-robin scheduler that shares one combinational carry-select adder among NREQ requesters using valid/ready handshakes. It arbitrates, drives the shared adder's operands, and registers each result with the winner's ID in a one-deep response slot. Multi-word additions lock the adder to one requester and carry `cout` into the next beat. It sits between the request sources and a single `carry_select_adder` instance (`INPUT_LEN` wide).

## Interface
- `W`, default `INPUT_LEN` (16): operand width; must equal the shared adder width.
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: requester ID width, clog2(NREQ).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set.
- `req_a`, `req_b`  in  NREQ*W  packed operands; requester i uses bits [(i+1)*W-1:i*W].
- `req_cin`  in  NREQ  carry-in for unchained beats.
- `req_chain`  in  NREQ  1 = more beats follow; hold the lock.
- `add_a`, `add_b`  out  W  operands to the shared adder.
- `add_cin`  out  1  carry-in to the shared adder.
- `add_o`  in  W  adder sum.
- `add_cout`  in  1  adder carry-out.
- `rsp_valid`  out  1  response slot full.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  requester that owns the response.
- `rsp_sum`  out  W  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_last`  out  1  1 = final beat of a chain, or a single beat.

## Operation
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant (combinational):
  - UNLOCKED: the first requester with `req_valid` set, searching from `ptr` upward modulo NREQ.
  - LOCKED: only `lock_id`.
  - `req_ready[g] = grant_valid && slot_free`.
- Shared adder drive:
  - `add_a`/`add_b` = the granted requester's operands.
  - `add_cin` = `carry_q` in LOCKED, else `req_cin[g]`.
  - With no grant, drive zeros.
- Accepting a beat (`req_valid[g] && req_ready[g]`) loads the slot:
  - `rsp_sum = add_o`, `rsp_cout = add_cout`, `rsp_id = g`, `rsp_last = !req_chain[g]`, `rsp_valid = 1`.
- States: UNLOCKED, LOCKED.
  - UNLOCKED → LOCKED: accepted beat with `req_chain=1`. Set `lock_id=g` and `carry_q=add_cout`.
  - LOCKED → LOCKED: accepted beat with `req_chain=1`. Set `carry_q=add_cout`.
  - LOCKED → UNLOCKED: accepted beat with `req_chain=0`.
  - Any accepted beat with `req_chain=0` sets `ptr = g+1` mod NREQ.
  - `ptr` is unchanged by chained beats.
- Lock hold: a locked requester that drops `req_valid` keeps the lock indefinitely. Other requesters stay blocked.
- Response drain: `rsp_valid && rsp_ready` with no new accept clears `rsp_valid`. The data fields hold their values.
- Simultaneous drain and accept in one cycle: the slot reloads with the new beat and `rsp_valid` stays 1.
- Arithmetic: plain W-bit modular addition. `rsp_cout` is the unsigned carry; no overflow flag.

## Timing
- Grant, `req_ready` and the `add_*` outputs are combinational from the inputs and state.
- Latency: a beat accepted at edge N is visible on `rsp_*` after edge N. Next-cycle response.
- Throughput: one beat per cycle while `rsp_ready=1`.
- `rsp_*` stays stable while `rsp_valid=1 && rsp_ready=0`. All `req_ready` bits are 0 during that time.
- Reset values:
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `rsp_last=0`.
  - `ptr=0`, state UNLOCKED, `lock_id=0`, `carry_q=0`.
- Reset mid-chain: drops the lock and any pending response with no further output. The requester must restart its chain.

## Configuration
- `ADDER_SCHED_STATS_EN`:
  - Defined: adds output `stat_beats` (16 bits), reset 0. It increments on every accepted beat and saturates at 0xFFFF. It also adds input `stat_clr` (1 bit), a synchronous clear. Clear wins over a same-cycle increment.
  - Undefined: neither port exists and no counter logic is built.

## Test plan
- Single beat: req0 a=0x00FF, b=0x0001, cin=0, chain=0. Expect `req_ready[0]=1` that cycle. Next cycle `rsp_valid=1`, sum=0x0100, cout=0, id=0, last=1.
- Round-robin: all 4 requesters valid, `rsp_ready=1`, chain=0. Expect grant order 0,1,2,3,0 on consecutive cycles with `rsp_id` matching, one cycle later.
- Chain: req2 sends beat 0xFFFF+0x0001 chain=1, then 0x0000+0x0000 chain=0, with req1 also valid. Expect responses id2 sum=0x0000 cout=1 last=0, then id2 sum=0x0001 cout=0 last=1. req1 is granted only after that.
- Backpressure: `rsp_ready=0` with the slot full and req3 valid. Expect `req_ready=0` and `rsp_*` frozen. Raise `rsp_ready`: the drain and the new accept happen in the same cycle and `rsp_valid` stays 1.
- Reset mid-chain: assert `rst` while LOCKED to req1. Expect immediately `rsp_valid=0`. After release, req0 is granted first (`ptr=0`) and its carry comes from `req_cin`.
- `ADDER_SCHED_STATS_EN`: run 5 accepted beats. Expect `stat_beats=5`. Pulse `stat_clr` during an accept: expect 0 the next cycle.
